// File: rtl/mult.sv
// Two-stage pipelined 128x128 -> 256-bit unsigned multiplier.
// Stage 1 registers the sixteen 32x32 limb products; stage 2 registers their weighted sum.
module mult (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] x,
  input  logic [127:0] y,
  output logic [127:0] ret,
  output logic [127:0] carry
);

  localparam int unsigned NumLimbs = 4;
  localparam int unsigned LimbW    = 32;
  localparam int unsigned NumPp    = NumLimbs * NumLimbs;

  logic [2*LimbW-1:0] pp_d [NumPp];
  logic [2*LimbW-1:0] pp_q [NumPp];
  logic [255:0]       sum_d;
  logic [255:0]       sum_q;

  // pp index i*4+j holds x limb i times y limb j.
  always_comb begin
    for (int i = 0; i < NumLimbs; i++) begin
      for (int j = 0; j < NumLimbs; j++) begin
        pp_d[i*NumLimbs+j] = 64'(x[LimbW*i +: LimbW]) * 64'(y[LimbW*j +: LimbW]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int k = 0; k < NumPp; k++) begin
        pp_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumPp; k++) begin
        pp_q[k] <= pp_d[k];
      end
    end
  end

  // The true product never exceeds 2^256-1, so a 256-bit accumulator cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NumLimbs; i++) begin
      for (int j = 0; j < NumLimbs; j++) begin
        sum_d = sum_d + (256'(pp_q[i*NumLimbs+j]) << (LimbW * (i + j)));
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign ret   = sum_q[127:0];
  assign carry = sum_q[255:128];

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: expected products are queued with the cycle they are due.
module tb_mult;

  logic         clk;
  logic         rst_n;
  logic [127:0] x;
  logic [127:0] y;
  logic [127:0] ret;
  logic [127:0] carry;

  typedef struct {
    int           due;
    logic [255:0] exp;
    string        tag;
  } sb_t;

  sb_t  sb_q[$];
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   fresh;

  mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .ret   (ret),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive at negedge+1; the following posedge samples, result visible two posedges later.
  task automatic drive(input logic [127:0] xv, input logic [127:0] yv,
                       input logic [255:0] expv, input string tag);
    sb_t e;
    @(negedge clk);
    #1;
    x = xv;
    y = yv;
    e.due = cyc + 2;
    e.exp = expv;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic drive_auto(input logic [127:0] xv, input logic [127:0] yv, input string tag);
    drive(xv, yv, 256'(xv) * 256'(yv), tag);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      check("in_reset", {carry, ret}, '0);
    end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check(e.tag, {carry, ret}, e.exp);
      fresh = 1'b0;
    end else if (fresh) begin
      check("post_reset_zero", {carry, ret}, '0);
    end
  end

  initial begin
    logic [127:0] xs;
    logic [127:0] ys;
    n_vec = 0;
    n_err = 0;
    fresh = 1'b1;
    rst_n = 1'b1;
    x = rand128();
    y = rand128();
    #1;
    check("reset_async", {carry, ret}, '0);

    // Random operands while held in reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      x = rand128();
      y = rand128();
    end

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    x = '1;
    y = '1;
    begin
      sb_t e;
      e.due = cyc + 2;
      e.exp = {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h00000000_00000000_00000000_00000001};
      e.tag = "max_x_max";
      sb_q.push_back(e);
    end

    drive(128'h1 << 127, 128'd2, {128'd1, 128'd0}, "msb_times_2");
    drive(128'd1, 128'h627240212decca515feab63e27345879,
          {128'd0, 128'h627240212decca515feab63e27345879}, "one_times_y");
    drive(128'd0, '1, '0, "zero_times_max");
    for (int i = 0; i < 4; i++) begin
      drive_auto(rand128(), rand128(), "random");
    end

    // Undefined operands for one cycle; only that result may be corrupt.
    @(negedge clk);
    #1;
    x = 'x;
    y = 'x;
    drive_auto(128'hDEADBEEF, 128'hCAFEF00D, "after_x");

    // Back-to-back incrementing stream.
    xs = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    ys = 128'h627240212decca515feab63e27345879;
    for (int i = 0; i < 20; i++) begin
      drive_auto(xs, ys, "stream");
      xs = xs + 1;
      ys = ys + 1;
    end

    // Mid-stream reset for one cycle discards everything in flight.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    fresh = 1'b1;
    x = rand128();
    y = rand128();
    #1;
    check("midstream_reset_async", {carry, ret}, '0);

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    x = xs;
    y = ys;
    begin
      sb_t e;
      e.due = cyc + 2;
      e.exp = 256'(xs) * 256'(ys);
      e.tag = "first_after_reset";
      sb_q.push_back(e);
    end
    for (int i = 1; i < 6; i++) begin
      drive_auto(xs + 128'(i), ys + 128'(i), "restream");
    end

    for (int i = 0; i < 3; i++) begin
      drive(128'd0, 128'd0, '0, "drain");
    end
    repeat (3) @(negedge clk);
    #2;
    check("scoreboard_empty", 256'(sb_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
